// File: rtl/hex_scroll_pkg.sv
// -----------------------------------------------------------------------------
// hex_scroll_pkg
// Shared definitions for the HEX0..HEX5 "HI" scroller control stage:
//   - 2-bit character codes carried on the DIGIT_CODE bus
//   - scroll FSM state type
//   - helpers for the position step rule and the per-digit code pattern
// No ports (package).
// -----------------------------------------------------------------------------
package hex_scroll_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int CODE_W     = 2 * NUM_DIGITS;

   localparam logic [1:0] CH_BLANK = 2'b00;
   localparam logic [1:0] CH_H     = 2'b01;
   localparam logic [1:0] CH_I     = 2'b10;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } scroll_state_t;

   // Next 'H' position; the pair wraps between digit 5 (HEX0) and digit 0 (HEX5).
   function automatic logic [2:0] pos_next(input logic [2:0] pos, input logic dir);
      logic [2:0] nxt;
      if (dir == 1'b0) begin
         nxt = (pos == 3'd5) ? 3'd0 : pos + 3'd1;
      end else begin
         nxt = (pos == 3'd0) ? 3'd5 : pos - 3'd1;
      end
      return nxt;
   endfunction

   // 'H' at digit pos, 'I' at digit (pos+1) mod 6, blanks elsewhere.
   // Digit 0 (HEX5) occupies the most significant code field.
   function automatic logic [CODE_W-1:0] digit_code(input logic [2:0] pos);
      logic [CODE_W-1:0] code;
      logic [2:0]        i_pos;
      i_pos = (pos == 3'd5) ? 3'd0 : pos + 3'd1;
      code  = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (3'(i) == pos) begin
            code[(NUM_DIGITS-1-i)*2 +: 2] = CH_H;
         end else if (3'(i) == i_pos) begin
            code[(NUM_DIGITS-1-i)*2 +: 2] = CH_I;
         end else begin
            code[(NUM_DIGITS-1-i)*2 +: 2] = CH_BLANK;
         end
      end
      return code;
   endfunction

endpackage

// File: rtl/hex_scroll_ctrl_if.sv
// -----------------------------------------------------------------------------
// hex_scroll_ctrl_if
// Bundles the raw pushbuttons and the scroller outputs.
//   KEY_PAUSE, KEY_DIR : raw active-low pushbuttons (async to clock)
//   POS                : digit index of 'H' (0 = HEX5 .. 5 = HEX0)
//   DIGIT_CODE         : 2-bit code per digit, [11:10] = HEX5 .. [1:0] = HEX0
//   STEP               : one-cycle pulse when POS/DIGIT_CODE update
//   PAUSED, DIR        : hold status and scroll direction
// master : the control stage (takes keys, drives outputs)
// slave  : board/encoder side (drives keys, consumes outputs)
// -----------------------------------------------------------------------------
interface hex_scroll_ctrl_if;
   import hex_scroll_pkg::*;

   logic              KEY_PAUSE;
   logic              KEY_DIR;
   logic [2:0]        POS;
   logic [CODE_W-1:0] DIGIT_CODE;
   logic              STEP;
   logic              PAUSED;
   logic              DIR;

   modport master (
      input  KEY_PAUSE, KEY_DIR,
      output POS, DIGIT_CODE, STEP, PAUSED, DIR
   );

   modport slave (
      output KEY_PAUSE, KEY_DIR,
      input  POS, DIGIT_CODE, STEP, PAUSED, DIR
   );

endinterface

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronizes one raw active-low pushbutton, accepts a new level only after
// DEBOUNCE_CYCLES consecutive equal synchronized samples, and emits a
// registered one-cycle pulse on each accepted press (debounced 1 -> 0).
//   clk, rst : clock, async active-high reset
//   key_raw  : raw pushbutton, active-low, asynchronous
//   press    : one-cycle press pulse
// -----------------------------------------------------------------------------
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic          sync1_r;
   logic          sync2_r;
   logic [CW-1:0] cnt_r;
   logic          level_r;
   logic          level_d_r;
   logic          press_r;

   // Two-flop synchronizer; released (1) out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= key_raw;
         sync2_r <= sync1_r;
      end
   end

   // Stability counter: counts consecutive samples that differ from the
   // accepted level; any agreeing sample restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r   <= '0;
         level_r <= 1'b1;
      end else if (sync2_r != level_r) begin
         if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_r <= sync2_r;
            cnt_r   <= '0;
         end else begin
            cnt_r   <= cnt_r + 1'b1;
         end
      end else begin
         cnt_r <= '0;
      end
   end

   // Press pulse on the accepted falling level; releases produce nothing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_d_r <= 1'b1;
         press_r   <= 1'b0;
      end else begin
         level_d_r <= level_r;
         press_r   <= level_d_r & ~level_r;
      end
   end

   assign press = press_r;

endmodule

// File: rtl/hex_scroll_ctrl.sv
// -----------------------------------------------------------------------------
// hex_scroll_ctrl
// Single-clock sequencer for the six-digit "HI" scroller. Divides CLOCK_50
// into a step tick, debounces the pause and direction keys, keeps the scroll
// position and drives a registered per-digit character code bus.
//   CLOCK_50 : sole clock
//   RST      : async active-high reset
//   bus      : hex_scroll_ctrl_if.master (keys in; POS, DIGIT_CODE, STEP,
//              PAUSED, DIR out, all registered)
// -----------------------------------------------------------------------------
module hex_scroll_ctrl
   import hex_scroll_pkg::*;
#(
   parameter int TICK_CYCLES     = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic              CLOCK_50,
   input  logic              RST,
   hex_scroll_ctrl_if.master bus
);

   localparam int PW = $clog2(TICK_CYCLES);

   scroll_state_t     state_r;
   logic [PW-1:0]     presc_r;
   logic [2:0]        pos_r;
   logic [CODE_W-1:0] code_r;
   logic              step_r;
   logic              paused_r;
   logic              dir_r;

   logic              pause_press_s;
   logic              dir_press_s;
   logic              tick_s;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_pause (
      .clk     (CLOCK_50),
      .rst     (RST),
      .key_raw (bus.KEY_PAUSE),
      .press   (pause_press_s)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dir (
      .clk     (CLOCK_50),
      .rst     (RST),
      .key_raw (bus.KEY_DIR),
      .press   (dir_press_s)
   );

   assign tick_s = (state_r == RUN) && (presc_r == PW'(TICK_CYCLES - 1));

   // Prescaler: counts only in RUN, so HOLD freezes it where it stands and
   // resuming continues from that value.
   always_ff @(posedge CLOCK_50 or posedge RST) begin
      if (RST) begin
         presc_r <= '0;
      end else if (state_r == RUN) begin
         presc_r <= (presc_r == PW'(TICK_CYCLES - 1)) ? '0 : presc_r + 1'b1;
      end else begin
         presc_r <= presc_r;
      end
   end

   // Scroll FSM with registered outputs. A pause press beats a coincident
   // tick; a direction press lands after any coincident step (old DIR used).
   always_ff @(posedge CLOCK_50 or posedge RST) begin
      if (RST) begin
         state_r  <= RUN;
         pos_r    <= 3'd0;
         code_r   <= digit_code(3'd0);
         step_r   <= 1'b0;
         paused_r <= 1'b0;
         dir_r    <= 1'b0;
      end else begin
         step_r <= 1'b0;
         if (dir_press_s) begin
            dir_r <= ~dir_r;
         end
         case (state_r)
            RUN: begin
               if (pause_press_s) begin
                  state_r  <= HOLD;
                  paused_r <= 1'b1;
               end else if (tick_s) begin
                  pos_r  <= pos_next(pos_r, dir_r);
                  code_r <= digit_code(pos_next(pos_r, dir_r));
                  step_r <= 1'b1;
               end
            end
            HOLD: begin
               if (pause_press_s) begin
                  state_r  <= RUN;
                  paused_r <= 1'b0;
               end
            end
            default: begin
               state_r  <= RUN;
               paused_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.POS        = pos_r;
   assign bus.DIGIT_CODE = code_r;
   assign bus.STEP       = step_r;
   assign bus.PAUSED     = paused_r;
   assign bus.DIR        = dir_r;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hex_scroll_ctrl
// Directed bench for hex_scroll_ctrl with TICK_CYCLES=8, DEBOUNCE_CYCLES=4.
// The stimulus process queues every expected step as {edge number, POS,
// DIGIT_CODE}; a monitor pops an entry on every STEP and compares it.
// Edge numbers count rising edges since the most recent reset release.
// -----------------------------------------------------------------------------
module tb_hex_scroll_ctrl;

   logic CLOCK_50 = 1'b0;
   logic RST      = 1'b1;
   int   cyc;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      int          cyc;
      logic [2:0]  pos;
      logic [11:0] code;
   } exp_t;

   exp_t exp_q[$];

   hex_scroll_ctrl_if bus ();

   hex_scroll_ctrl #(
      .TICK_CYCLES     (8),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .RST      (RST),
      .bus      (bus)
   );

   initial forever #5 CLOCK_50 = ~CLOCK_50;

   // Edge counter since reset release.
   always @(posedge CLOCK_50 or posedge RST) begin
      if (RST) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push(input int c, input logic [2:0] p, input logic [11:0] code);
      exp_t e;
      e.cyc  = c;
      e.pos  = p;
      e.code = code;
      exp_q.push_back(e);
   endtask

   // Advance to #1 after rising edge n.
   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pos"},    32'(bus.POS),        32'd0);
      chk({tag, "_code"},   32'(bus.DIGIT_CODE), 32'h600);
      chk({tag, "_step"},   32'(bus.STEP),       32'd0);
      chk({tag, "_paused"}, 32'(bus.PAUSED),     32'd0);
      chk({tag, "_dir"},    32'(bus.DIR),        32'd0);
   endtask

   // Monitor: every STEP must match the oldest queued expectation.
   always @(negedge CLOCK_50) begin
      if (!RST && bus.STEP) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_step", 32'(bus.POS), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("step_edge", 32'(cyc),            32'(e.cyc));
            chk("step_pos",  32'(bus.POS),        32'(e.pos));
            chk("step_code", 32'(bus.DIGIT_CODE), 32'(e.code));
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.KEY_PAUSE = 1'b1;
      bus.KEY_DIR   = 1'b1;
      #12;
      chk_reset_vals("reset");
      @(negedge CLOCK_50);
      RST = 1'b0;

      // Free run.
      push(8,  3'd1, 12'h180);
      push(16, 3'd2, 12'h060);
      push(24, 3'd3, 12'h018);
      push(32, 3'd4, 12'h006);
      push(40, 3'd5, 12'h801);
      push(48, 3'd0, 12'h600);

      // Pause with prescaler at 3, hold, resume from the frozen value.
      push(56,  3'd1, 12'h180);
      push(113, 3'd2, 12'h060);
      push(121, 3'd3, 12'h018);
      push(129, 3'd4, 12'h006);
      push(137, 3'd5, 12'h801);
      push(145, 3'd0, 12'h600);
      goto(51);
      bus.KEY_PAUSE = 1'b0;
      goto(58);
      chk("paused_before", 32'(bus.PAUSED), 32'd0);
      goto(59);
      chk("paused_set", 32'(bus.PAUSED), 32'd1);
      goto(61);
      bus.KEY_PAUSE = 1'b1;
      goto(100);
      bus.KEY_PAUSE = 1'b0;
      goto(107);
      chk("paused_still", 32'(bus.PAUSED), 32'd1);
      goto(108);
      chk("paused_clear", 32'(bus.PAUSED), 32'd0);
      goto(110);
      bus.KEY_PAUSE = 1'b1;

      // Short direction glitch: rejected.
      goto(130);
      bus.KEY_DIR = 1'b0;
      goto(133);
      bus.KEY_DIR = 1'b1;
      goto(140);
      chk("dir_glitch", 32'(bus.DIR), 32'd0);

      // Direction press while POS=0, then wrap to 5.
      push(153, 3'd5, 12'h801);
      push(161, 3'd4, 12'h006);
      push(169, 3'd3, 12'h018);
      push(177, 3'd2, 12'h060);
      push(185, 3'd3, 12'h018);
      bus.KEY_DIR = 1'b0;
      goto(146);
      bus.KEY_DIR = 1'b1;
      goto(147);
      chk("dir_before", 32'(bus.DIR), 32'd0);
      goto(148);
      chk("dir_set", 32'(bus.DIR), 32'd1);
      chk("dir_pos0", 32'(bus.POS), 32'd0);

      // Direction press coinciding with a tick: old DIR used for that step.
      goto(169);
      bus.KEY_DIR = 1'b0;
      goto(175);
      bus.KEY_DIR = 1'b1;
      goto(176);
      chk("dir_coll_before", 32'(bus.DIR), 32'd1);
      goto(177);
      chk("dir_coll_after", 32'(bus.DIR), 32'd0);

      // Pause press coinciding with a tick: no step.
      goto(185);
      bus.KEY_PAUSE = 1'b0;
      goto(192);
      chk("coll_pre_paused", 32'(bus.PAUSED), 32'd0);
      goto(193);
      chk("coll_paused", 32'(bus.PAUSED), 32'd1);
      chk("coll_pos",    32'(bus.POS),    32'd3);
      chk("coll_step",   32'(bus.STEP),   32'd0);
      bus.KEY_PAUSE = 1'b1;

      // Both keys pressed together: resume and toggle direction.
      push(216, 3'd2, 12'h060);
      push(224, 3'd1, 12'h180);
      push(232, 3'd0, 12'h600);
      push(240, 3'd5, 12'h801);
      push(248, 3'd4, 12'h006);
      push(256, 3'd3, 12'h018);
      goto(200);
      bus.KEY_PAUSE = 1'b0;
      bus.KEY_DIR   = 1'b0;
      goto(207);
      chk("both_pre_paused", 32'(bus.PAUSED), 32'd1);
      goto(208);
      chk("both_paused", 32'(bus.PAUSED), 32'd0);
      chk("both_dir",    32'(bus.DIR),    32'd1);
      goto(210);
      bus.KEY_PAUSE = 1'b1;
      bus.KEY_DIR   = 1'b1;

      // Async reset between edges at POS=3, prescaler=3.
      goto(259);
      chk("pre_reset_pos", 32'(bus.POS), 32'd3);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      #3;
      RST = 1'b1;
      #1;
      chk_reset_vals("async_reset");
      push(8,  3'd1, 12'h180);
      push(16, 3'd2, 12'h060);
      repeat (2) @(negedge CLOCK_50);
      RST = 1'b0;
      goto(20);
      chk("final_queue", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hex_scroll_ctrl.md
# hex_scroll_ctrl

Upstream control stage for the six-digit HEX0–HEX5 "HI" scroller on the 50 MHz board.
- Divides CLOCK_50 into a step tick and debounces two pushbuttons: pause/resume and direction.
- Keeps the scroll position and emits a registered per-digit character code bus.
- A downstream 7-segment encoder turns that bus into active-low HEX patterns.
- Replaces free-running ripple-clock scrolling with a single-clock, resettable, user-controllable sequencer.

## Interface
Parameters:
- TICK_CYCLES, 50_000_000, CLOCK_50 cycles per scroll step (1 Hz default); ≥2
- DEBOUNCE_CYCLES, 500_000, cycles a synchronized key level must be stable to be accepted (10 ms); ≥2

Ports:
- CLOCK_50  in  1  sole clock, all flops rising-edge
- RST  in  1  reset, asynchronous, active-high
- KEY_PAUSE  in  1  raw pushbutton, active-low, asynchronous to clock
- KEY_DIR  in  1  raw pushbutton, active-low, asynchronous to clock
- POS  out  3  digit index of 'H', 0..5; 0 = HEX5 (leftmost), 5 = HEX0
- DIGIT_CODE  out  12  2-bit code per digit; [11:10]=HEX5 … [1:0]=HEX0; 00 blank, 01 'H', 10 'I', 11 unused
- STEP  out  1  one-cycle pulse in the cycle POS/DIGIT_CODE take a new value
- PAUSED  out  1  1 while scrolling is held
- DIR  out  1  0 = left-to-right (POS increments), 1 = right-to-left

## Operation
- Key path, per key: 2-FF synchronizer, then stability counter. The debounced level updates only after DEBOUNCE_CYCLES consecutive equal synchronized samples. A 1→0 transition of the debounced level produces a one-cycle press pulse.
- Prescaler: counts 0..TICK_CYCLES-1; tick asserted for the one cycle in which count = TICK_CYCLES-1, then wraps to 0.
- FSM, two states:
  - RUN: prescaler counts. Tick advances POS. Pause press → HOLD.
  - HOLD: prescaler frozen at its current value (not cleared), no steps. Pause press → RUN, counting resumes from the frozen value.
- Step rule:
  - DIR=0: POS = (POS==5) ? 0 : POS+1.
  - DIR=1: POS = (POS==0) ? 5 : POS-1.
- DIGIT_CODE: 'H' at digit POS; 'I' at digit (POS+1) mod 6 in both directions; all other digits blank. The pair wraps across the HEX0→HEX5 boundary, so POS=5 gives 'I' on HEX5 and 'H' on HEX0.
- Direction press toggles DIR in either FSM state.
- Simultaneous events:
  - Pause press in the same cycle as tick (RUN): pause wins, no step, POS unchanged.
  - Dir press in the same cycle as tick: the step uses the old DIR; the new DIR applies from the next tick.
  - Both key presses in the same cycle: both take effect.
- PAUSED = (state == HOLD).
- Reset values, applied immediately on RST high with no clock edge required:
  - POS=0, DIGIT_CODE=12'h600, STEP=0, PAUSED=0, DIR=0
  - FSM=RUN, prescaler=0
  - synchronizers and debounced levels = 1 (released), debounce counters = 0

## Timing
- All outputs registered. STEP, POS and DIGIT_CODE change on the clock edge following the tick cycle.
- First STEP after reset release: TICK_CYCLES cycles after the first active edge. Then exactly every TICK_CYCLES cycles while in RUN.
- Key latency: raw edge → press pulse = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles. PAUSED/DIR change on the edge after the press pulse.
- Key glitches shorter than DEBOUNCE_CYCLES: no press pulse.
- Release bounces: debounced like presses; they produce no pulse.

## Structure
- Package hex_scroll_pkg: char code constants CH_BLANK=2'b00, CH_H=2'b01, CH_I=2'b10; FSM state enum {RUN, HOLD}; NUM_DIGITS=6.
- Sub-module key_debounce (synchronizer + stability counter + press-pulse detect, parameter DEBOUNCE_CYCLES), instantiated twice.
- Prescaler, FSM, position counter and code generator live in the top module.

## Test plan
Sim params: TICK_CYCLES=8, DEBOUNCE_CYCLES=4.
- Free-run after reset: STEP every 8 cycles; POS 0,1,2,3,4,5,0. DIGIT_CODE at POS=1 is 12'h180; at POS=5 is 12'h801.
- Pause: KEY_PAUSE low 10 cycles at prescaler=3 → PAUSED=1 at 8 cycles after the fall, no STEP for 40 cycles. Second press → PAUSED=0, next STEP after the remaining count from the frozen value.
- Bounce: KEY_DIR low for 3 cycles, then high → DIR stays 0, no press pulse.
- Direction wrap: DIR press while POS=0 → DIR=1; next STEP gives POS=5, DIGIT_CODE=12'h801; following STEP gives POS=4, 12'h006.
- Collision: pause press pulse aligned with the tick cycle → no STEP, POS unchanged, PAUSED=1.
- Async reset at POS=3 mid-prescale, asserted between clock edges → outputs at reset values before the next edge; resumes from POS=0 after release.
